// File: rtl/qgemm_pkg.sv
// Shared quantized-GEMM constants, geometry helpers and packer state encoding.
// Combinational helpers only; no timing or flow-control behaviour here.
package qgemm_pkg;

  localparam int BIT_NUM_D   = 8;
  localparam int MAT_SIZE_D  = 16;
  localparam int FP_DATA_W_D = 32;
  localparam int FP_EXP_W_D  = 8;
  localparam int FP_MANT_W_D = 23;
  localparam int LANES_NUM_D = 16;
  localparam int OUT_W_D     = 512;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int in_beats(input int mat_size, input int lanes_num);
    return (mat_size * mat_size) / lanes_num;
  endfunction

  function automatic int group_n(input int out_w, input int lanes_num, input int bit_num);
    return out_w / (lanes_num * bit_num);
  endfunction

  function automatic int words_n(input int mat_size, input int lanes_num, input int out_w,
                                 input int bit_num);
    return in_beats(mat_size, lanes_num) / group_n(out_w, lanes_num, bit_num);
  endfunction

  function automatic int hdr_exp_lsb(input int mat_size, input int fp_mant_w);
    return mat_size * fp_mant_w;
  endfunction

  localparam int HDR_MANT_LSB = 0;
  localparam int HDR_EXP_LSB  = hdr_exp_lsb(MAT_SIZE_D, FP_MANT_W_D);

  typedef enum logic {S_SCL, S_PACK} state_t;

endpackage

// File: rtl/qtile_packer_if.sv
// Scale, quantized-beat and packed-word handshake bundle for the tile packer.
// master drives scales/beats and downstream ready; slave is the packer.
interface qtile_packer_if
  import qgemm_pkg::*;
#(
  parameter int MAT_SIZE  = MAT_SIZE_D,
  parameter int FP_EXP_W  = FP_EXP_W_D,
  parameter int FP_MANT_W = FP_MANT_W_D,
  parameter int LANES_NUM = LANES_NUM_D,
  parameter int FP_DATA_W = FP_DATA_W_D,
  parameter int OUT_W     = OUT_W_D
) ();

  logic                            scl_valid_i;
  logic                            scl_ready_o;
  logic [FP_MANT_W*MAT_SIZE-1:0]   mantissa_scale_i;
  logic [FP_EXP_W*MAT_SIZE-1:0]    exp_scale_i;
  logic                            s_valid_i;
  logic                            s_ready_o;
  logic [LANES_NUM*FP_DATA_W-1:0]  s_data_i;
  logic                            m_valid_o;
  logic                            m_ready_i;
  logic [OUT_W-1:0]                m_data_o;
  logic                            m_last_o;

  modport master (
    output scl_valid_i, mantissa_scale_i, exp_scale_i, s_valid_i, s_data_i, m_ready_i,
    input  scl_ready_o, s_ready_o, m_valid_o, m_data_o, m_last_o
  );

  modport slave (
    input  scl_valid_i, mantissa_scale_i, exp_scale_i, s_valid_i, s_data_i, m_ready_i,
    output scl_ready_o, s_ready_o, m_valid_o, m_data_o, m_last_o
  );

endinterface

// File: rtl/qlane_narrow.sv
// Strips each sign-extended lane to BIT_NUM bits and flags lanes outside the signed range.
// Purely combinational; no flow control.
module qlane_narrow #(
  parameter int LANES_NUM = 16,
  parameter int FP_DATA_W = 32,
  parameter int BIT_NUM   = 8
) (
  input  logic [LANES_NUM*FP_DATA_W-1:0] wide,
  output logic [LANES_NUM*BIT_NUM-1:0]   narrow,
  output logic                           ovf
);

  logic [LANES_NUM-1:0] lane_bad;

  for (genvar li = 0; li < LANES_NUM; li++) begin : g_lane
    // sign bit of the narrow value plus everything above it must agree
    logic [FP_DATA_W-BIT_NUM:0] top_bits;
    assign top_bits = wide[li*FP_DATA_W+BIT_NUM-1 +: FP_DATA_W-BIT_NUM+1];
    assign narrow[li*BIT_NUM +: BIT_NUM] = wide[li*FP_DATA_W +: BIT_NUM];
    assign lane_bad[li] = !((&top_bits) || !(|top_bits));
  end

  assign ovf = |lane_bad;

endmodule

// File: rtl/qtile_packer.sv
// Frames one tile as a scale header plus packed quantized words behind a single output register.
// Words appear one cycle after the completing input; inputs stall while the register holds an unaccepted word.
module qtile_packer
  import qgemm_pkg::*;
#(
  parameter int BIT_NUM   = BIT_NUM_D,
  parameter int MAT_SIZE  = MAT_SIZE_D,
  parameter int FP_DATA_W = FP_DATA_W_D,
  parameter int FP_EXP_W  = FP_EXP_W_D,
  parameter int FP_MANT_W = FP_MANT_W_D,
  parameter int LANES_NUM = LANES_NUM_D,
  parameter int OUT_W     = OUT_W_D
) (
  input  logic                 clk,
  input  logic                 rstnn,
  qtile_packer_if.slave        bus,
  output logic                 ovf_o,
  input  logic                 ovf_clr_i,
  output logic [15:0]          tile_cnt_o
);

  localparam int BEAT_PW = LANES_NUM * BIT_NUM;
  localparam int GROUP   = group_n(OUT_W, LANES_NUM, BIT_NUM);
  localparam int WORDS   = words_n(MAT_SIZE, LANES_NUM, OUT_W, BIT_NUM);
  localparam int EXP_LSB = hdr_exp_lsb(MAT_SIZE, FP_MANT_W);
  localparam int BG_W    = (clog2(GROUP) > 0) ? clog2(GROUP) : 1;
  localparam int WC_W    = (clog2(WORDS) > 0) ? clog2(WORDS) : 1;

  if ((OUT_W % BEAT_PW) != 0 ||
      (in_beats(MAT_SIZE, LANES_NUM) % GROUP) != 0 ||
      MAT_SIZE * (FP_EXP_W + FP_MANT_W) > OUT_W) begin : g_bad_cfg
    $fatal(1, "qtile_packer: inconsistent geometry parameters");
  end

  state_t            state;
  logic [BG_W-1:0]   beat_in_group;
  logic [WC_W-1:0]   word_cnt;
  logic [OUT_W-1:0]  accumulator;
  logic              m_valid;
  logic [OUT_W-1:0]  m_data;
  logic              m_last;

  logic [BEAT_PW-1:0] narrow;
  logic               lane_ovf;
  logic               slot_free;
  logic               scl_fire;
  logic               beat_fire;
  logic               group_done;
  logic               tile_done;
  logic [OUT_W-1:0]   merged;
  logic [OUT_W-1:0]   header;

  qlane_narrow #(
    .LANES_NUM (LANES_NUM),
    .FP_DATA_W (FP_DATA_W),
    .BIT_NUM   (BIT_NUM)
  ) u_narrow (
    .wide   (bus.s_data_i),
    .narrow (narrow),
    .ovf    (lane_ovf)
  );

  assign slot_free       = !m_valid || bus.m_ready_i;
  assign bus.scl_ready_o = (state == S_SCL) && slot_free;
  assign bus.s_ready_o   = (state == S_PACK) && slot_free;
  assign scl_fire        = bus.scl_valid_i && bus.scl_ready_o;
  assign beat_fire       = bus.s_valid_i && bus.s_ready_o;
  assign group_done      = (beat_in_group == BG_W'(GROUP - 1));
  assign tile_done       = (word_cnt == WC_W'(WORDS - 1));

  always_comb begin
    header = '0;
    header[HDR_MANT_LSB +: MAT_SIZE*FP_MANT_W] = bus.mantissa_scale_i;
    header[EXP_LSB +: MAT_SIZE*FP_EXP_W]       = bus.exp_scale_i;
  end

  // the completing beat is merged here so the full word loads without an extra cycle
  always_comb begin
    merged = accumulator;
    merged[int'(beat_in_group)*BEAT_PW +: BEAT_PW] = narrow;
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state         <= S_SCL;
      beat_in_group <= '0;
      word_cnt      <= '0;
      accumulator   <= '0;
      m_valid       <= 1'b0;
      m_data        <= '0;
      m_last        <= 1'b0;
      ovf_o         <= 1'b0;
      tile_cnt_o    <= '0;
    end else begin
      if (m_valid && bus.m_ready_i) begin
        m_valid <= 1'b0;
        if (m_last) tile_cnt_o <= tile_cnt_o + 16'd1;
      end

      case (state)
        S_SCL: begin
          if (scl_fire) begin
            m_data  <= header;
            m_valid <= 1'b1;
            m_last  <= 1'b0;
            state   <= S_PACK;
          end
        end
        S_PACK: begin
          if (beat_fire) begin
            if (group_done) begin
              m_data        <= merged;
              m_valid       <= 1'b1;
              m_last        <= tile_done;
              accumulator   <= '0;
              beat_in_group <= '0;
              if (tile_done) begin
                word_cnt <= '0;
                state    <= S_SCL;
              end else begin
                word_cnt <= word_cnt + WC_W'(1);
              end
            end else begin
              accumulator   <= merged;
              beat_in_group <= beat_in_group + BG_W'(1);
            end
          end
        end
        default: state <= S_SCL;
      endcase

      if (beat_fire && lane_ovf) ovf_o <= 1'b1;
      else if (ovf_clr_i)        ovf_o <= 1'b0;
    end
  end

  assign bus.m_valid_o = m_valid;
  assign bus.m_data_o  = m_data;
  assign bus.m_last_o  = m_last;

endmodule

// File: doc/qtile_packer.md
Name: qtile_packer

Overview:
- Sits directly downstream of the row-wise quantizer.
- Accepts one per-row scale set per tile, then the tile's quantized lanes. Each lane is a BIT_NUM-bit integer sign-extended to FP_DATA_W.
- Strips each lane to BIT_NUM bits and packs several input beats into each OUT_W-bit word.
- Emits one framed packet per tile to the DMA/GEMM operand buffer: one scale header word, then the packed data words, with m_last on the final word.

Parameters:
- BIT_NUM, 8, quantized element width.
- MAT_SIZE, 16, tile edge; the tile holds MAT_SIZE*MAT_SIZE elements.
- FP_DATA_W, 32, input lane width.
- FP_EXP_W, 8, exponent-scale width per row.
- FP_MANT_W, 23, mantissa-scale width per row.
- LANES_NUM, 16, lanes per input beat.
- OUT_W, 512, output word width.
- Derived values: IN_BEATS = MAT_SIZE²/LANES_NUM; BEAT_PW = LANES_NUM*BIT_NUM; GROUP = OUT_W/BEAT_PW; WORDS = IN_BEATS/GROUP.
- Elaboration $fatal unless all of the following hold: OUT_W%BEAT_PW==0, IN_BEATS%GROUP==0, MAT_SIZE*(FP_EXP_W+FP_MANT_W) ≤ OUT_W.

Ports:
- clk  in  1  clock.
- rstnn  in  1  asynchronous active-low reset.
- scl_valid_i  in  1  scale set valid.
- scl_ready_o  out  1  scale set accepted.
- mantissa_scale_i  in  FP_MANT_W*MAT_SIZE  per-row mantissa scales; row k at slice k.
- exp_scale_i  in  FP_EXP_W*MAT_SIZE  per-row exponent scales.
- s_valid_i  in  1  quantized beat valid.
- s_ready_o  out  1  quantized beat accepted.
- s_data_i  in  LANES_NUM*FP_DATA_W  sign-extended quantized lanes; lane li at slice li.
- m_valid_o  out  1  output word valid.
- m_ready_i  in  1  downstream ready.
- m_data_o  out  OUT_W  header or packed data word.
- m_last_o  out  1  final word of the tile packet.
- ovf_o  out  1  sticky lane-range error.
- ovf_clr_i  in  1  synchronous clear of ovf_o.
- tile_cnt_o  out  16  number of completed tile packets; wraps modulo 2^16.

Behaviour:
- Reset: clk is the clock; rstnn is an asynchronous, active-low reset. On reset:
  - state=S_SCL, beat_in_group=0, word_cnt=0, accumulator=0.
  - m_valid_o=0, m_data_o=0, m_last_o=0, ovf_o=0, tile_cnt_o=0.
  - Reset mid-packet discards all partial data; no word is emitted afterwards until a new scale handshake.
- Single output register. Define slot_free = !m_valid_o || m_ready_i. m_valid_o clears on handshake unless reloaded in the same cycle.
- State S_SCL:
  - scl_ready_o = slot_free; s_ready_o=0.
  - On scl fire, load header into the output register: m_data_o[MAT_SIZE*FP_MANT_W-1:0] = mantissa_scale_i, the next MAT_SIZE*FP_EXP_W bits = exp_scale_i, remaining bits zero.
  - Set m_valid_o=1, m_last_o=0, then go to S_PACK.
- State S_PACK:
  - s_ready_o = slot_free; scl_ready_o=0.
  - On beat fire, lane li's low BIT_NUM bits go to accumulator[beat_in_group*BEAT_PW + li*BIT_NUM +: BIT_NUM].
  - When beat_in_group==GROUP-1: load the output register with the packed word (current beat merged combinationally into the accumulator), set m_valid_o=1, zero the accumulator, set beat_in_group=0, increment word_cnt.
  - m_last_o=1 when word_cnt==WORDS-1. On that load go to S_SCL and set word_cnt=0.
- Latency: a data word appears one cycle after the beat that completes its group. The header appears one cycle after the scale handshake.
- Back-pressure: while the output register holds an unaccepted word, neither input is accepted. An accept and a reload in the same cycle (m_ready_i=1) is full throughput. Sustained rate: 1 beat/cycle in, 1 word per GROUP cycles out.
- Overflow check: if any lane's bits [FP_DATA_W-1:BIT_NUM-1] are not all equal on an accepted beat, set ovf_o. The value is still truncated and packed.
  - ovf_clr_i clears ovf_o. If a clear and a set occur in the same cycle, set wins.
- tile_cnt_o increments on the handshake of a word with m_last_o=1.
- Ordering guarantee: packet = header, then WORDS data words. A new tile's header cannot overtake the previous last word, because the single slot is gated by slot_free.
- Inputs presented in the wrong state are held, not dropped: scale is ignored in S_PACK, beats are ignored in S_SCL.

Decomposition:
- Shared package qgemm_pkg holds:
  - BIT_NUM, MAT_SIZE, LANES_NUM, FP widths, OUT_W defaults.
  - Derived IN_BEATS/GROUP/WORDS functions and clog2.
  - Header field offsets (HDR_MANT_LSB, HDR_EXP_LSB).
  - The state enum {S_SCL, S_PACK}.
- One sub-module: qlane_narrow. It is combinational and does per-beat narrowing plus the range check: LANES_NUM*FP_DATA_W in, BEAT_PW out plus an ovf bit.

Test Plan:
- Defaults; scales mant row k=k, exp row k=0x80+k; 16 beats, lane li of beat b = b*16+li (wrapped to int8, sign-extended); m_ready_i=1 → 5 words:
  - header bits[22:0]=0, exp field row0=0x80;
  - data word0 byte0=0x00, byte63=0x3F;
  - m_last_o only on word 5; tile_cnt_o=1.
- Lanes = 0xFFFFFF80 (-128) and 0x0000007F → packed bytes 0x80/0x7F; ovf_o stays 0.
- One lane = 0x00000080 → byte 0x80 is packed and ovf_o=1. Then ovf_clr_i pulsed → ovf_o=0. Then a clear coinciding with a new bad lane → ovf_o=1.
- m_ready_i toggled 1-of-3 cycles with random s_valid_i → word contents identical to the first test; no beat accepted while a word is stalled; m_data_o stable while m_valid_o && !m_ready_i.
- Two back-to-back tiles with m_ready_i=1 → header of tile 2 appears the cycle after tile 1's last word handshake; tile_cnt_o=2.
- rstnn asserted after 7 beats → outputs zero immediately. After release, a new full tile produces a clean 5-word packet with no residue from the aborted tile.
